// File: rtl/control_packet_receiver_pkg.sv
// Shared framing constants, receiver state encoding and default sizing
// for the switch control-port packet receiver.
package control_packet_receiver_pkg;

  localparam logic [7:0] CTRL_HEADER  = 8'hFF;
  localparam logic [7:0] CTRL_TRAILER = 8'h55;
  localparam int         DEFAULT_MAX_LEN = 64;

  typedef enum logic [2:0] {
    ST_HUNT    = 3'd0,
    ST_DA      = 3'd1,
    ST_SA      = 3'd2,
    ST_LEN     = 3'd3,
    ST_PAYLOAD = 3'd4,
    ST_PARITY  = 3'd5,
    ST_DELIVER = 3'd6
  } rx_state_t;

endpackage

// File: rtl/ctrl_payload_buffer.sv
// Payload store: one write port and one asynchronous read port over a
// MAX_LEN x 8 register array.
module ctrl_payload_buffer
  import control_packet_receiver_pkg::*;
#(
  parameter int MAX_LEN = DEFAULT_MAX_LEN,
  parameter int IDX_W   = 6
) (
  input  logic             clock,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [7:0]       wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [7:0]       rd_data
);

  logic [7:0] mem [MAX_LEN];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/control_packet_receiver.sv
// Control-port receiver: hunts for the header, checks length and parity,
// buffers the payload and replays DA/SA/LEN/payload on a valid/ready stream.
module control_packet_receiver
  import control_packet_receiver_pkg::*;
#(
  parameter int MAX_LEN = DEFAULT_MAX_LEN,
  parameter int CNT_W   = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [7:0]       data_in,
  input  logic             sw_enable_in,
  output logic             read_out,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic             out_sop,
  output logic             out_last,
  input  logic             out_ready,
  output logic             err_parity,
  output logic             err_length,
  output logic [CNT_W-1:0] good_count,
  output logic [CNT_W-1:0] drop_count
);

  localparam int         IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  rx_state_t  state;
  logic [7:0] pay_idx;
  logic [8:0] beat;
  logic [7:0] da, sa, len, par;

  logic [8:0] nb, nb_sub;
  logic       nb_last;
  logic [7:0] rd_data;
  logic       wr_en;
  logic       accept;

  assign accept   = sw_enable_in;
  assign read_out = (state == ST_HUNT);
  assign wr_en    = (state == ST_PAYLOAD) && accept;

  // Beat numbering: 0 = DA, 1 = SA, 2 = LEN, 3+k = payload byte k.
  assign nb      = beat + 9'd1;
  assign nb_sub  = nb - 9'd3;
  assign nb_last = (nb == 9'd2) ? (len == 8'd0)
                 : ((nb >= 9'd3) && ((nb_sub + 9'd1) == {1'b0, len}));

  ctrl_payload_buffer #(.MAX_LEN(MAX_LEN), .IDX_W(IDX_W)) u_buf (
    .clock  (clock),
    .wr_en  (wr_en),
    .wr_idx (pay_idx[IDX_W-1:0]),
    .wr_data(data_in),
    .rd_idx (nb_sub[IDX_W-1:0]),
    .rd_data(rd_data)
  );

  // Captured header fields and running parity; no reset needed.
  always_ff @(posedge clock) begin
    if (accept) begin
      case (state)
        ST_DA:      begin da  <= data_in; par <= data_in;       end
        ST_SA:      begin sa  <= data_in; par <= par ^ data_in; end
        ST_LEN:     begin len <= data_in; par <= par ^ data_in; end
        ST_PAYLOAD: par <= par ^ data_in;
        default:    ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_HUNT;
      pay_idx    <= 8'd0;
      beat       <= 9'd0;
      out_valid  <= 1'b0;
      out_data   <= 8'd0;
      out_sop    <= 1'b0;
      out_last   <= 1'b0;
      err_parity <= 1'b0;
      err_length <= 1'b0;
      good_count <= '0;
      drop_count <= '0;
    end else begin
      err_parity <= 1'b0;
      err_length <= 1'b0;
      case (state)
        ST_HUNT: if (accept && data_in == CTRL_HEADER) state <= ST_DA;
        ST_DA:   if (accept) state <= ST_SA;
        ST_SA:   if (accept) state <= ST_LEN;
        ST_LEN: begin
          if (accept) begin
            if (data_in > MAX_LEN_B) begin
              err_length <= 1'b1;
              drop_count <= sat_inc(drop_count);
              state      <= ST_HUNT;
            end else if (data_in == 8'd0) begin
              state <= ST_PARITY;
            end else begin
              pay_idx <= 8'd0;
              state   <= ST_PAYLOAD;
            end
          end
        end
        ST_PAYLOAD: begin
          if (accept) begin
            pay_idx <= pay_idx + 8'd1;
            if (({1'b0, pay_idx} + 9'd1) == {1'b0, len}) state <= ST_PARITY;
          end
        end
        ST_PARITY: begin
          if (accept) begin
            if (data_in == par) begin
              out_valid <= 1'b1;
              out_data  <= da;
              out_sop   <= 1'b1;
              out_last  <= 1'b0;
              beat      <= 9'd0;
              state     <= ST_DELIVER;
            end else begin
              err_parity <= 1'b1;
              drop_count <= sat_inc(drop_count);
              state      <= ST_HUNT;
            end
          end
        end
        ST_DELIVER: begin
          if (out_valid && out_ready) begin
            if (out_last) begin
              out_valid  <= 1'b0;
              out_sop    <= 1'b0;
              out_last   <= 1'b0;
              good_count <= sat_inc(good_count);
              state      <= ST_HUNT;
            end else begin
              beat     <= nb;
              out_sop  <= 1'b0;
              out_last <= nb_last;
              out_data <= (nb == 9'd1) ? sa : (nb == 9'd2) ? len : rd_data;
            end
          end
        end
        default: state <= ST_HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_control_packet_receiver.sv
// Directed self-checking bench for control_packet_receiver.
module tb_control_packet_receiver;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [7:0] data_in;
  logic       sw_enable_in;
  logic       read_out;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_sop;
  logic       out_last;
  logic       out_ready;
  logic       err_parity;
  logic       err_length;
  logic [7:0] good_count;
  logic [7:0] drop_count;

  int checks = 0;
  int errors = 0;
  int perr_seen = 0;
  int lerr_seen = 0;

  logic [7:0] bd [0:79];
  logic       bs [0:79];
  logic       bl [0:79];
  int         n;

  always #5 clock = ~clock;

  control_packet_receiver #(.MAX_LEN(64), .CNT_W(8)) dut (
    .clock(clock), .reset_n(reset_n), .data_in(data_in), .sw_enable_in(sw_enable_in),
    .read_out(read_out), .out_valid(out_valid), .out_data(out_data), .out_sop(out_sop),
    .out_last(out_last), .out_ready(out_ready), .err_parity(err_parity),
    .err_length(err_length), .good_count(good_count), .drop_count(drop_count)
  );

  always @(negedge clock) begin
    if (err_parity) perr_seen++;
    if (err_length) lerr_seen++;
  end

  task automatic send(input logic [7:0] b);
    data_in = b;
    sw_enable_in = 1'b1;
    @(posedge clock); #1;
    sw_enable_in = 1'b0;
  endtask

  task automatic gap();
    sw_enable_in = 1'b0;
    data_in = 8'h55;
    @(posedge clock); #1;
  endtask

  // Records output beats until a last beat or the cycle budget runs out.
  task automatic collect(input int max_cycles);
    int  cyc;
    bit  done;
    cyc = 0; done = 0; n = 0;
    out_ready = 1'b1;
    while (!done && cyc < max_cycles) begin
      if (out_valid && n < 80) begin
        bd[n] = out_data; bs[n] = out_sop; bl[n] = out_last;
        if (out_last) done = 1;
        n++;
      end
      @(posedge clock); #1;
      cyc++;
    end
  endtask

  task automatic send_good();
    send(8'hFF); send(8'h01); send(8'h02); send(8'h02);
    send(8'h10); send(8'h20); send(8'h31);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; sw_enable_in = 1'b0; data_in = 8'h00; out_ready = 1'b1;
    #12;
    checks++; if (read_out !== 1'b1) begin errors++; $display("FAIL reset_read_out: got %0b expected 1", read_out); end
    checks++; if ({out_valid, out_sop, out_last, err_parity, err_length} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 00000", {out_valid, out_sop, out_last, err_parity, err_length}); end
    checks++; if ({out_data, good_count, drop_count} !== 24'h0) begin
      errors++; $display("FAIL reset_data_counts: got %h expected 000000", {out_data, good_count, drop_count}); end
    @(negedge clock); reset_n = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_good();
    logic [7:0] e [0:4] = '{8'h01, 8'h02, 8'h02, 8'h10, 8'h20};
    send(8'hFF);
    checks++; if (read_out !== 1'b0) begin errors++; $display("FAIL good_read_out_low: got %0b expected 0", read_out); end
    send(8'h01); send(8'h02); send(8'h02); send(8'h10); send(8'h20); send(8'h31);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL good_first_latency: got %0b expected 1", out_valid); end
    collect(20);
    checks++; if (n !== 5) begin errors++; $display("FAIL good_beat_count: got %0d expected 5", n); end
    for (int i = 0; i < 5 && i < n; i++) begin
      checks++;
      if (bd[i] !== e[i] || bs[i] !== (i == 0) || bl[i] !== (i == 4)) begin
        errors++; $display("FAIL good_beat%0d: got %h/%b/%b expected %h/%b/%b", i, bd[i], bs[i], bl[i], e[i], i == 0, i == 4);
      end
    end
    checks++; if (good_count !== 8'd1) begin errors++; $display("FAIL good_count1: got %0d expected 1", good_count); end
    checks++; if (perr_seen + lerr_seen !== 0) begin errors++; $display("FAIL good_no_err: got %0d expected 0", perr_seen + lerr_seen); end
  endtask

  task automatic test_gapped();
    logic [7:0] e [0:4] = '{8'h01, 8'h02, 8'h02, 8'h10, 8'h20};
    send(8'hFF); send(8'h01); send(8'h02); gap(); gap(); send(8'h02);
    send(8'h10); gap(); send(8'h20); gap(); gap(); send(8'h31);
    collect(20);
    checks++; if (n !== 5) begin errors++; $display("FAIL gap_beat_count: got %0d expected 5", n); end
    for (int i = 0; i < 5 && i < n; i++) begin
      checks++;
      if (bd[i] !== e[i] || bs[i] !== (i == 0) || bl[i] !== (i == 4)) begin
        errors++; $display("FAIL gap_beat%0d: got %h/%b/%b expected %h/%b/%b", i, bd[i], bs[i], bl[i], e[i], i == 0, i == 4);
      end
    end
    checks++; if (read_out !== 1'b1) begin errors++; $display("FAIL gap_read_out_back: got %0b expected 1", read_out); end
    checks++; if (good_count !== 8'd2) begin errors++; $display("FAIL gap_count: got %0d expected 2", good_count); end
  endtask

  task automatic test_bad_parity();
    send(8'hFF); send(8'h01); send(8'h02); send(8'h02); send(8'h10); send(8'h20); send(8'h30);
    checks++; if (err_parity !== 1'b1) begin errors++; $display("FAIL parity_pulse: got %0b expected 1", err_parity); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL parity_no_valid: got %0b expected 0", out_valid); end
    checks++; if (drop_count !== 8'd1) begin errors++; $display("FAIL parity_drop: got %0d expected 1", drop_count); end
    gap();
    checks++; if (err_parity !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL parity_pulse_width: got %0b/%0b expected 0/0", err_parity, out_valid); end
    send_good();
    collect(20);
    checks++; if (n !== 5 || bd[4] !== 8'h20 || good_count !== 8'd3) begin
      errors++; $display("FAIL parity_recover: got n=%0d last=%h good=%0d expected n=5 last=20 good=3", n, bd[4], good_count); end
  endtask

  task automatic test_length();
    logic [7:0] p;
    send(8'hFF); send(8'h01); send(8'h02); send(8'h41);
    checks++; if (err_length !== 1'b1 || read_out !== 1'b1) begin
      errors++; $display("FAIL len_over: got err=%0b ready=%0b expected 1/1", err_length, read_out); end
    checks++; if (drop_count !== 8'd2) begin errors++; $display("FAIL len_drop: got %0d expected 2", drop_count); end
    // Exactly MAX_LEN payload bytes 0..63: their XOR is 0, parity is 01^02^40.
    send(8'hFF); send(8'h01); send(8'h02); send(8'h40);
    for (int i = 0; i < 64; i++) begin p = 8'(i); send(p); end
    send(8'h43);
    collect(100);
    checks++; if (n !== 67 || bd[66] !== 8'h3F || bl[66] !== 1'b1 || bl[65] !== 1'b0 || bd[3] !== 8'h00) begin
      errors++; $display("FAIL len_max: got n=%0d last=%h/%b expected n=67 last=3f/1", n, bd[66], bl[66]); end
    send(8'hFF); send(8'h0A); send(8'h0B); send(8'h00); send(8'h01);
    collect(20);
    checks++; if (n !== 3 || bd[0] !== 8'h0A || bs[0] !== 1'b1 || bd[1] !== 8'h0B || bl[1] !== 1'b0
                  || bd[2] !== 8'h00 || bl[2] !== 1'b1) begin
      errors++; $display("FAIL len_zero: got n=%0d %h %h %h last=%b expected n=3 0a 0b 00 last=1", n, bd[0], bd[1], bd[2], bl[2]); end
    checks++; if (good_count !== 8'd5 || lerr_seen !== 1) begin
      errors++; $display("FAIL len_counts: got good=%0d lerr=%0d expected 5/1", good_count, lerr_seen); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b1;
    send_good();
    checks++; if (out_data !== 8'h01 || out_sop !== 1'b1) begin
      errors++; $display("FAIL bp_da: got %h/%b expected 01/1", out_data, out_sop); end
    @(posedge clock); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      data_in = 8'hFF; sw_enable_in = 1'b1;
      @(posedge clock); #1;
      checks++; if (out_valid !== 1'b1 || out_data !== 8'h02 || out_sop !== 1'b0 || out_last !== 1'b0) begin
        errors++; $display("FAIL bp_hold%0d: got %b/%h/%b/%b expected 1/02/0/0", i, out_valid, out_data, out_sop, out_last); end
    end
    sw_enable_in = 1'b0;
    collect(20);
    checks++; if (n !== 4 || bd[0] !== 8'h02 || bd[1] !== 8'h02 || bd[2] !== 8'h10 || bd[3] !== 8'h20 || bl[3] !== 1'b1) begin
      errors++; $display("FAIL bp_rest: got n=%0d %h %h %h %h expected 4 beats 02 02 10 20", n, bd[0], bd[1], bd[2], bd[3]); end
    checks++; if (read_out !== 1'b1 || good_count !== 8'd6) begin
      errors++; $display("FAIL bp_done: got ready=%0b good=%0d expected 1/6", read_out, good_count); end
    send(8'hFF); send(8'h01); send(8'h02); send(8'h03); send(8'h10);
    #2 reset_n = 1'b0;
    #1;
    checks++; if (read_out !== 1'b1 || out_valid !== 1'b0 || good_count !== 8'd0 || drop_count !== 8'd0 || out_data !== 8'd0) begin
      errors++; $display("FAIL rst_mid: got ready=%0b valid=%0b good=%0d drop=%0d data=%h expected 1/0/0/0/00",
                         read_out, out_valid, good_count, drop_count, out_data); end
    @(negedge clock); reset_n = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_noise_saturation();
    send(8'h55); send(8'h00); send(8'hFE);
    checks++; if (read_out !== 1'b1) begin errors++; $display("FAIL noise_ignored: got %0b expected 1", read_out); end
    send_good();
    collect(20);
    checks++; if (n !== 5 || bd[0] !== 8'h01 || good_count !== 8'd1) begin
      errors++; $display("FAIL noise_packet: got n=%0d first=%h good=%0d expected 5/01/1", n, bd[0], good_count); end
    for (int k = 0; k < 300; k++) begin
      send(8'hFF); send(8'h01); send(8'h02); send(8'h00); send(8'h00);
      if (k == 254) begin
        checks++; if (drop_count !== 8'hFF) begin errors++; $display("FAIL sat_reach: got %h expected ff", drop_count); end
      end
    end
    checks++; if (drop_count !== 8'hFF || good_count !== 8'd1) begin
      errors++; $display("FAIL sat_hold: got drop=%h good=%0d expected ff/1", drop_count, good_count); end
  endtask

  initial begin
    test_reset();
    test_good();
    test_gapped();
    test_bad_parity();
    test_length();
    test_backpressure();
    test_noise_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
